lsu_mem_initiator: RTL

//  CPU-side initiator for the instruction/data memory request interface (mem_wren/mem_rden/mem_ready).

---
 rtl/lsu_mem_initiator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store initiator toward a level-request memory with ready pulse.
// Aligns store lanes/strobes, extends load data, flags misalignment and memory timeouts.
module lsu_mem_initiator #(
    parameter int ADDR_LSB = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    output logic        lsu_accept,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err_align,
    output logic        lsu_err_tmo,
    output logic        mem_wren,
    output logic        mem_rden,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q, done_q, err_align_q, err_tmo_q, wren_q, rden_q;
    logic [31:0] rdata_q, addr_q, wdata_q;
    logic [3:0]  strb_q;

    logic        illegal, misalign;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d, ext_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;

    // Stores only exist as B/H/W; the unsigned encodings are load-only.
    assign illegal  = lsu_funct3[1:0] == 2'b11 || (lsu_funct3[2] && (lsu_funct3[1] || lsu_we));
    assign misalign = (lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                      (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00);
    assign strb_d   = !lsu_we ? 4'b0000 :
                      lsu_funct3[1:0] == 2'b00 ? 4'b0001 << lsu_addr[1:0] :
                      lsu_funct3[1:0] == 2'b01 ? 4'b0011 << lsu_addr[1:0] : 4'b1111;
    assign wdata_d  = lsu_funct3[1:0] == 2'b00 ? {4{lsu_wdata[7:0]}} :
                      lsu_funct3[1:0] == 2'b01 ? {2{lsu_wdata[15:0]}} : lsu_wdata;
    assign byte_d   = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_d   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    assign ext_d    = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_d[7]}}, byte_d} :
                      f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_d[15]}}, half_d} : mem_rdata;

    assign lsu_accept    = state_q == IDLE;
    assign lsu_done      = done_q;
    assign lsu_rdata     = rdata_q;
    assign lsu_err_align = err_align_q;
    assign lsu_err_tmo   = err_tmo_q;
    assign mem_wren      = wren_q;
    assign mem_rden      = rden_q;
    assign mem_addr      = addr_q;
    assign mem_wstrb     = strb_q;
    assign mem_wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            rdata_q     <= '0;
            case (state_q)
                IDLE: if (lsu_valid) begin
                    if (illegal || misalign) begin
                        done_q      <= 1'b1;
                        err_align_q <= 1'b1;
                    end else begin
                        addr_q  <= {{ADDR_LSB{1'b0}}, lsu_addr[31:ADDR_LSB]};
                        strb_q  <= strb_d;
                        wdata_q <= wdata_d;
                        off_q   <= lsu_addr[1:0];
                        f3_q    <= lsu_funct3;
                        we_q    <= lsu_we;
                        wren_q  <= lsu_we;
                        rden_q  <= ~lsu_we;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: if (mem_ready) begin
                    wren_q  <= 1'b0;
                    rden_q  <= 1'b0;
                    done_q  <= 1'b1;
                    rdata_q <= we_q ? 32'd0 : ext_d;
                    state_q <= GAP;
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    wren_q    <= 1'b0;
                    rden_q    <= 1'b0;
                    done_q    <= 1'b1;
                    err_tmo_q <= 1'b1;
                    state_q   <= GAP;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
